// File: rtl/rv32_pkg.sv
// Shared RV32 decode constants and helpers, plus the branch predictor's FSM state type.
package rv32_pkg;

  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  localparam logic [4:0] LinkX1 = 5'd1;
  localparam logic [4:0] LinkX5 = 5'd5;

  typedef enum logic [0:0] {StInit, StRun} bp_state_e;

  function automatic logic is_link(logic [4:0] r);
    return (r == LinkX1) || (r == LinkX5);
  endfunction

  function automatic logic [31:0] imm_b(logic [31:0] instr);
    return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(logic [31:0] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  function automatic logic [1:0] sat_update(logic [1:0] ctr, logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken && ctr != 2'b11) res = ctr + 2'b01;
    else if (!taken && ctr != 2'b00) res = ctr - 2'b01;
    return res;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic        replace,
  input  logic [31:0] data,
  output logic [31:0] top,
  output logic        empty
);

  localparam int unsigned PtrBits = $clog2(DEPTH);

  logic [31:0]        mem [DEPTH];
  logic [PtrBits-1:0] ptr_q;
  logic [PtrBits-1:0] top_ptr;
  logic [PtrBits:0]   count_q;

  assign top_ptr = ptr_q - PtrBits'(1);
  assign top     = mem[top_ptr];
  assign empty   = (count_q == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[ptr_q] <= data;
    end else if (replace) begin
      mem[top_ptr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else if (push) begin
      ptr_q <= ptr_q + PtrBits'(1);
      if (count_q != (PtrBits + 1)'(DEPTH)) count_q <= count_q + (PtrBits + 1)'(1);
    end else if (pop && !empty) begin
      ptr_q   <= top_ptr;
      count_q <= count_q - (PtrBits + 1)'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Gshare conditional-branch predictor with a return-address stack for calls and returns.
module branch_predictor
  import rv32_pkg::*;
#(
  parameter int unsigned BHT_ADDR_BITS = 12,
  parameter int unsigned HIST_BITS     = 9,
  parameter int unsigned RAS_DEPTH     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              f_pc,
  input  logic                     f_stall,
  input  logic                     d_valid,
  input  logic                     d_stall,
  input  logic [31:0]              d_pc,
  input  logic [31:0]              d_instr,
  output logic                     d_take,
  output logic [31:0]              d_target,
  output logic [BHT_ADDR_BITS-1:0] d_idx,
  input  logic                     e_branch,
  input  logic                     e_taken,
  input  logic [BHT_ADDR_BITS-1:0] e_idx,
  output logic                     ready
);

  localparam int unsigned Entries = 2 ** BHT_ADDR_BITS;

  typedef logic [BHT_ADDR_BITS-1:0] idx_t;

  bp_state_e            state_q;
  logic                 ready_q;
  idx_t                 sweep_q;
  logic [HIST_BITS-1:0] ghr_q;
  logic [HIST_BITS-1:0] ghr_d;
  idx_t                 f_idx;
  idx_t                 idx_q;
  logic [1:0]           ctr_q;
  logic [1:0]           pht [Entries];

  // Updates are read-modify-write over two cycles so both table reads stay registered.
  logic       upd_fire;
  logic       upd_pend_q;
  logic       upd_taken_q;
  idx_t       upd_idx_q;
  logic [1:0] upd_raw_q;
  logic       fwd_hit_q;
  logic [1:0] fwd_val_q;
  logic [1:0] upd_old;
  logic [1:0] upd_new;

  logic       pht_we;
  idx_t       pht_waddr;
  logic [1:0] pht_wdata;

  assign ready    = ready_q;
  assign d_idx    = idx_q;
  assign upd_fire = e_branch && ready_q;
  assign f_idx    = f_pc[BHT_ADDR_BITS+1:2] ^ idx_t'(ghr_q);

  if (HIST_BITS == 1) begin : g_ghr_one
    assign ghr_d = e_taken;
  end else begin : g_ghr_shift
    assign ghr_d = {ghr_q[HIST_BITS-2:0], e_taken};
  end

  assign upd_old = fwd_hit_q ? fwd_val_q : upd_raw_q;
  assign upd_new = sat_update(upd_old, upd_taken_q);

  always_comb begin
    pht_we    = upd_pend_q;
    pht_waddr = upd_idx_q;
    pht_wdata = upd_new;
    if (state_q == StInit) begin
      pht_we    = 1'b1;
      pht_waddr = sweep_q;
      pht_wdata = 2'b01;
    end
  end

  // Read-first table: a lookup on the write edge sees the previous contents.
  always_ff @(posedge clk) begin
    if (pht_we) pht[pht_waddr] <= pht_wdata;
    if (!f_stall) ctr_q <= pht[f_idx];
    upd_raw_q <= pht[e_idx];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StInit;
      ready_q     <= 1'b0;
      sweep_q     <= '0;
      ghr_q       <= '0;
      idx_q       <= '0;
      upd_pend_q  <= 1'b0;
      upd_taken_q <= 1'b0;
      upd_idx_q   <= '0;
      fwd_hit_q   <= 1'b0;
      fwd_val_q   <= '0;
    end else begin
      case (state_q)
        StInit: begin
          sweep_q <= sweep_q + idx_t'(1);
          if (sweep_q == '1) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end
        end
        default: ;
      endcase
      if (!f_stall) idx_q <= f_idx;
      upd_pend_q <= upd_fire;
      if (upd_fire) begin
        ghr_q       <= ghr_d;
        upd_idx_q   <= e_idx;
        upd_taken_q <= e_taken;
        // Back-to-back updates of one entry: the raw read misses the in-flight write.
        fwd_hit_q   <= upd_pend_q && (upd_idx_q == e_idx);
        fwd_val_q   <= upd_new;
      end
    end
  end

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic        rd_link;
  logic        rs1_link;
  logic        act;
  logic        ras_push;
  logic        ras_pop;
  logic        ras_replace;
  logic [31:0] ras_data;
  logic [31:0] ras_top;
  logic        ras_empty;

  assign opcode   = d_instr[6:0];
  assign rd       = d_instr[11:7];
  assign rs1      = d_instr[19:15];
  assign rd_link  = is_link(rd);
  assign rs1_link = is_link(rs1);
  assign act      = d_valid && !d_stall && ready_q;
  assign ras_data = d_pc + 32'd4;

  always_comb begin
    d_take      = 1'b0;
    d_target    = d_pc + 32'd4;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    ras_replace = 1'b0;
    case (opcode)
      OpcBranch: begin
        d_take   = ctr_q[1];
        d_target = d_pc + imm_b(d_instr);
      end
      OpcJal: begin
        d_take   = 1'b1;
        d_target = d_pc + imm_j(d_instr);
        ras_push = rd_link;
      end
      OpcJalr: begin
        if (rs1_link && !rd_link) begin
          if (!ras_empty) begin
            d_take   = 1'b1;
            d_target = {ras_top[31:1], 1'b0};
            ras_pop  = 1'b1;
          end
        end else if (rs1_link && rd_link && (rd != rs1)) begin
          // Coroutine swap; with nothing to return to it degenerates to a call.
          if (!ras_empty) begin
            d_take      = 1'b1;
            d_target    = {ras_top[31:1], 1'b0};
            ras_replace = 1'b1;
          end else begin
            ras_push = 1'b1;
          end
        end else if (rd_link && (rd == rs1)) begin
          ras_push = 1'b1;
        end
      end
      default: ;
    endcase
    if (!act) begin
      d_take      = 1'b0;
      ras_push    = 1'b0;
      ras_pop     = 1'b0;
      ras_replace = 1'b0;
    end
  end

  ras_stack #(
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk    (clk),
    .reset  (reset),
    .push   (ras_push),
    .pop    (ras_pop),
    .replace(ras_replace),
    .data   (ras_data),
    .top    (ras_top),
    .empty  (ras_empty)
  );

  logic unused_bits;
  assign unused_bits = ^{f_pc[31:BHT_ADDR_BITS+2], f_pc[1:0], ras_top[0], ctr_q[0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: gshare training, RAS call/return behaviour, stalls and reset sweeps.
module tb_branch_predictor;

  localparam int unsigned Bab = 4;
  localparam int unsigned Hb  = 3;
  localparam int unsigned Rd  = 2;

  localparam int KBr   = 0;
  localparam int KJal  = 1;
  localparam int KJalr = 2;
  localparam int KAlu  = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [31:0]    f_pc;
  logic           f_stall;
  logic           d_valid;
  logic           d_stall;
  logic [31:0]    d_pc;
  logic [31:0]    d_instr;
  logic           d_take;
  logic [31:0]    d_target;
  logic [Bab-1:0] d_idx;
  logic           e_branch;
  logic           e_taken;
  logic [Bab-1:0] e_idx;
  logic           ready;

  always #5 clk = ~clk;

  branch_predictor #(
    .BHT_ADDR_BITS(Bab),
    .HIST_BITS    (Hb),
    .RAS_DEPTH    (Rd)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .f_pc    (f_pc),
    .f_stall (f_stall),
    .d_valid (d_valid),
    .d_stall (d_stall),
    .d_pc    (d_pc),
    .d_instr (d_instr),
    .d_take  (d_take),
    .d_target(d_target),
    .d_idx   (d_idx),
    .e_branch(e_branch),
    .e_taken (e_taken),
    .e_idx   (e_idx),
    .ready   (ready)
  );

  int checks = 0;
  int errors = 0;

  logic [1:0]    pht_m [16];
  logic [Hb-1:0] ghr_m;
  logic [1:0]    look_ctr_m;
  logic [31:0]   ras_m [$];

  typedef struct {
    string       tag;
    logic        take;
    logic [31:0] tgt;
    bit          chk_tgt;
  } exp_t;
  exp_t sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    ghr_m = '0;
    for (int i = 0; i < 16; i++) pht_m[i] = 2'b01;
    ras_m.delete();
  endtask

  task automatic model_update(input logic [3:0] idx, input logic tk);
    if (tk && pht_m[idx] != 2'b11) pht_m[idx] = pht_m[idx] + 2'b01;
    else if (!tk && pht_m[idx] != 2'b00) pht_m[idx] = pht_m[idx] - 2'b01;
    ghr_m = {ghr_m[Hb-2:0], tk};
  endtask

  task automatic lookup(input logic [31:0] pc);
    logic [3:0] idx;
    idx     = pc[5:2] ^ {1'b0, ghr_m};
    f_pc    = pc;
    f_stall = 1'b0;
    step();
    check("lookup_idx", {28'd0, d_idx}, {28'd0, idx});
    look_ctr_m = pht_m[idx];
  endtask

  task automatic update(input logic [3:0] idx, input logic tk);
    e_branch = 1'b1;
    e_idx    = idx;
    e_taken  = tk;
    step();
    e_branch = 1'b0;
    model_update(idx, tk);
  endtask

  task automatic decode(input string tag, input logic [31:0] pc, input int kind,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm,
                        input logic stall);
    logic [31:0] instr;
    exp_t        e;
    exp_t        got;
    bit          rdl, rsl, do_push, do_pop, do_rep;
    rdl       = (rd == 5'd1) || (rd == 5'd5);
    rsl       = (rs1 == 5'd1) || (rs1 == 5'd5);
    do_push   = 0;
    do_pop    = 0;
    do_rep    = 0;
    e.tag     = tag;
    e.take    = 1'b0;
    e.tgt     = pc + 32'd4;
    e.chk_tgt = !stall;
    case (kind)
      KBr: begin
        instr  = {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'b1100011};
        e.take = look_ctr_m[1];
        e.tgt  = pc + imm;
      end
      KJal: begin
        instr   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
        e.take  = 1'b1;
        e.tgt   = pc + imm;
        do_push = rdl;
      end
      KJalr: begin
        instr = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
        if (rsl && !rdl) begin
          if (ras_m.size() > 0) begin
            e.take = 1'b1;
            e.tgt  = ras_m[$] & ~32'd1;
            do_pop = 1;
          end
        end else if (rsl && rdl && rd != rs1) begin
          if (ras_m.size() > 0) begin
            e.take = 1'b1;
            e.tgt  = ras_m[$] & ~32'd1;
            do_rep = 1;
          end else begin
            do_push = 1;
          end
        end else if (rdl && rd == rs1) begin
          do_push = 1;
        end
      end
      default: instr = {12'h000, 5'd0, 3'b000, rd, 7'b0010011};
    endcase
    if (stall) begin
      e.take  = 1'b0;
      do_push = 0;
      do_pop  = 0;
      do_rep  = 0;
    end
    sb.push_back(e);
    d_valid = 1'b1;
    d_stall = stall;
    d_pc    = pc;
    d_instr = instr;
    #1;
    got = sb.pop_front();
    check({got.tag, "_take"}, {31'd0, d_take}, {31'd0, got.take});
    if (got.chk_tgt) check({got.tag, "_target"}, d_target, got.tgt);
    step();
    d_valid = 1'b0;
    d_stall = 1'b0;
    if (do_push) begin
      ras_m.push_back(pc + 32'd4);
      if (ras_m.size() > Rd) ras_m.delete(0);
    end
    if (do_pop) void'(ras_m.pop_back());
    if (do_rep) ras_m[ras_m.size()-1] = pc + 32'd4;
  endtask

  task automatic wait_ready(input string tag, input bit watch_take);
    int n;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      n++;
      if (ready === 1'b1) break;
      if (watch_take) check({tag, "_sweep_take"}, {31'd0, d_take}, 32'd0);
    end
    d_valid = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'd16);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    f_pc     = '0;
    f_stall  = 1'b0;
    d_valid  = 1'b0;
    d_stall  = 1'b0;
    d_pc     = '0;
    d_instr  = '0;
    e_branch = 1'b0;
    e_taken  = 1'b0;
    e_idx    = '0;
    model_reset();
    repeat (3) step();
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_idx", {28'd0, d_idx}, 32'd0);

    // A JAL x1 held valid through reset and sweep must never redirect.
    d_valid = 1'b1;
    d_pc    = 32'h50;
    d_instr = {1'b0, 10'h008, 1'b0, 8'h00, 5'd1, 7'b1101111};
    #1;
    check("reset_take", {31'd0, d_take}, 32'd0);
    reset = 1'b1;
    wait_ready("init", 1);

    lookup(32'h100);
    decode("br_weak", 32'h100, KBr, 5'd0, 5'd0, 32'hFFFF_FFF8, 1'b0);
    update(4'd0, 1'b1);
    update(4'd0, 1'b1);
    step();
    lookup(32'h10C);
    decode("br_strong", 32'h100, KBr, 5'd0, 5'd0, 32'hFFFF_FFF8, 1'b0);
    update(4'd0, 1'b1);
    step();
    lookup(32'h11C);
    decode("br_sat", 32'h100, KBr, 5'd0, 5'd0, 32'hFFFF_FFF8, 1'b0);
    update(4'd0, 1'b0);
    step();
    lookup(32'h118);
    decode("br_sat_dec", 32'h100, KBr, 5'd0, 5'd0, 32'hFFFF_FFF8, 1'b0);
    update(4'd0, 1'b0);
    step();
    lookup(32'h110);
    decode("br_weak_again", 32'h100, KBr, 5'd0, 5'd0, 32'hFFFF_FFF8, 1'b0);

    // Lookup and update on the same edge: old counter, old history.
    begin
      logic [3:0] idx;
      idx      = 4'h0 ^ {1'b0, ghr_m};
      f_pc     = 32'h100;
      e_branch = 1'b1;
      e_idx    = idx;
      e_taken  = 1'b1;
      step();
      e_branch = 1'b0;
      check("same_edge_idx", {28'd0, d_idx}, {28'd0, idx});
      look_ctr_m = pht_m[idx];
      model_update(idx, 1'b1);
    end
    decode("br_same_edge", 32'h100, KBr, 5'd0, 5'd0, 32'hFFFF_FFF8, 1'b0);
    update(4'd4, 1'b1);
    step();
    lookup(32'h11C);
    decode("br_trained", 32'h11C, KBr, 5'd0, 5'd0, 32'h10, 1'b0);

    lookup(32'h120);
    begin
      logic [3:0] held;
      held    = d_idx;
      f_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
        f_pc = 32'h140 + 32'(i * 4);
        step();
        check("fstall_hold", {28'd0, d_idx}, 32'd11);
      end
      f_stall = 1'b0;
      check("fstall_first", {28'd0, held}, 32'd11);
    end
    lookup(32'h150);

    decode("jal_call", 32'h200, KJal, 5'd1, 5'd0, 32'h100, 1'b0);
    decode("ret", 32'h300, KJalr, 5'd0, 5'd1, 32'h0, 1'b0);
    decode("ret_empty", 32'h304, KJalr, 5'd0, 5'd1, 32'h0, 1'b0);

    decode("push_10", 32'h0C, KJal, 5'd1, 5'd0, 32'h100, 1'b0);
    decode("push_20", 32'h1C, KJal, 5'd5, 5'd0, 32'h100, 1'b0);
    decode("push_30", 32'h2C, KJal, 5'd1, 5'd0, 32'h100, 1'b0);
    decode("pop_30", 32'h500, KJalr, 5'd0, 5'd1, 32'h0, 1'b0);
    decode("pop_20", 32'h510, KJalr, 5'd0, 5'd5, 32'h0, 1'b0);
    decode("pop_empty", 32'h520, KJalr, 5'd0, 5'd1, 32'h0, 1'b0);

    decode("co_call", 32'h3C, KJal, 5'd1, 5'd0, 32'h40, 1'b0);
    decode("coroutine", 32'h80, KJalr, 5'd1, 5'd5, 32'h0, 1'b0);
    decode("co_ret", 32'h90, KJalr, 5'd0, 5'd1, 32'h0, 1'b0);
    decode("co_empty", 32'h94, KJalr, 5'd0, 5'd1, 32'h0, 1'b0);
    decode("link_push", 32'hA0, KJalr, 5'd5, 5'd5, 32'h0, 1'b0);
    decode("link_ret", 32'hA8, KJalr, 5'd0, 5'd5, 32'h0, 1'b0);
    decode("jalr_other", 32'hB0, KJalr, 5'd2, 5'd3, 32'h0, 1'b0);
    decode("alu_op", 32'hC0, KAlu, 5'd1, 5'd0, 32'h0, 1'b0);
    decode("alu_ret", 32'hC4, KJalr, 5'd0, 5'd1, 32'h0, 1'b0);

    decode("jal_stall0", 32'h400, KJal, 5'd1, 5'd0, 32'h40, 1'b1);
    decode("jal_stall1", 32'h400, KJal, 5'd1, 5'd0, 32'h40, 1'b1);
    decode("jal_go", 32'h400, KJal, 5'd1, 5'd0, 32'h40, 1'b0);
    decode("stall_ret", 32'h440, KJalr, 5'd0, 5'd1, 32'h0, 1'b0);
    decode("stall_ret2", 32'h444, KJalr, 5'd0, 5'd1, 32'h0, 1'b0);

    decode("pre_reset_call", 32'h600, KJal, 5'd1, 5'd0, 32'h10, 1'b0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    model_reset();
    repeat (7) step();
    check("mid_sweep_ready", {31'd0, ready}, 32'd0);
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    wait_ready("resweep", 0);
    decode("ret_after_reset", 32'h700, KJalr, 5'd0, 5'd1, 32'h0, 1'b0);
    lookup(32'h110);
    decode("br_after_reset", 32'h110, KBr, 5'd0, 5'd0, 32'h20, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
